mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the machine's single-port RAM between the CPU and a DMA/loader port, one access per cycle, with fixed-priority or round-robin arbitration and a bounded DMA lock for bursts. Sits between `cpu`, the loader/debug master and `ram` inside `machine`, replacing the direct CPU-to-RAM connection. Grants are combinational from the current state. Read data returns one cycle after the grant.

## Interface
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `LOCK_MAX`, 4: maximum consecutive granted DMA beats under lock (1..15).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req`, `cpu_we` in 1: CPU access request; write when high.
- `cpu_addr` in ADDR_W, `cpu_wdata` in DATA_W: CPU access address and write data.
- `cpu_gnt` out 1: CPU access accepted this cycle.
- `cpu_rvalid` out 1: CPU read data valid.
- `cpu_rdata` out DATA_W: CPU read data.
- `dma_req`, `dma_we`, `dma_lock` in 1: DMA request, write flag, and burst-lock request.
- `dma_addr` in ADDR_W, `dma_wdata` in DATA_W: DMA access address and write data.
- `dma_gnt`, `dma_rvalid` out 1: DMA grant and read-data valid.
- `dma_rdata` out DATA_W: DMA read data.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W, `ram_wdata` out DATA_W: RAM address and write data.
- `ram_rdata` in DATA_W: RAM read data, valid one cycle after the address is presented.
- `busy` out 1: high while in ARB_LOCK.

## Operation
- States:
  - ARB_IDLE: normal arbitration.
  - ARB_LOCK: DMA owns the bus exclusively.
- ARB_IDLE grant rules:
  - Only one requester: that requester is granted.
  - Both requesting, macro off: DMA wins, unless `boost` is set, in which case CPU wins.
- ARB_LOCK grant rules:
  - `cpu_gnt` is 0.
  - `dma_gnt` equals `dma_req`.
- Grant exclusivity: at most one of `cpu_gnt`/`dma_gnt` is high in any cycle.
- RAM drive:
  - The granted requester's `we`/`addr`/`wdata` drive the `ram_*` outputs.
  - With no grant, `ram_we`=0 and `ram_addr`/`ram_wdata` hold the CPU values. No write occurs.
- Lock counter `lcnt`:
  - Width is the ceiling of log2(LOCK_MAX+1).
  - Increments on every granted DMA beat while in ARB_LOCK.
- IDLE -> LOCK: on a granted DMA beat with `dma_lock`=1. `lcnt` is set to 1.
- LOCK -> IDLE, on the first of these:
  - `dma_req`=0.
  - A granted beat with `dma_lock`=0; that beat is still performed.
  - `lcnt` reaches LOCK_MAX on a granted beat. This case also sets `boost`.
- `boost` flag:
  - Set as above.
  - Cleared after the next IDLE arbitration cycle, whatever its outcome.
  - Guarantees the CPU one access after a maximal burst.
- Read return:
  - `cpu_rvalid`/`dma_rvalid` are registered copies of (gnt & !we) for each port.
  - `cpu_rdata` and `dma_rdata` both pass `ram_rdata` through. Data is only meaningful while the matching `rvalid` is high.
- Reset mid-operation:
  - State returns to ARB_IDLE; `lcnt`=0, `boost`=0, `last`=CPU.
  - Both `rvalid` outputs are 0 on the next cycle, so an in-flight read is dropped.
- Reset values:
  - `cpu_gnt`/`dma_gnt` = 0 while `reset` is high; grants are gated by reset.
  - `cpu_rvalid`, `dma_rvalid`, `busy`, `ram_we` = 0.

## Timing
- Cycle N: request high and grant high; address presented to RAM; a write commits at the end of N.
- Cycle N+1: `rvalid` high and `rdata` valid for a read granted in N.
- Back-to-back grants are allowed every cycle. Full throughput is one access per cycle.
- A requester must hold `req`/`addr`/`we`/`wdata` stable until it sees its grant.
- A requester may drop `req` at any time before its grant, with no side effect.
- Worst-case CPU wait with both requesting:
  - Round-robin: 1 cycle.
  - Fixed priority: unbounded while DMA requests without lock; LOCK_MAX+1 cycles after a maximal locked burst.
- `lcnt` must never exceed LOCK_MAX.

## Configuration
- Macro: `MEM_ARB_RR_EN`.
- Defined:
  - Both-requesting ties in ARB_IDLE alternate, using a `last` register (reset = CPU, so DMA wins the first tie).
  - `last` updates on every grant.
  - `boost` still takes precedence over `last`.
- Undefined: fixed DMA priority as described above; `last` is not implemented.
- ARB_LOCK behaviour is identical in both builds.

## Structure
- Package `machine_pkg`:
  - `arb_state_t` enum (ARB_IDLE, ARB_LOCK).
  - `arb_owner_t` enum (OWN_CPU, OWN_DMA).
  - Default constants for address width, data width and LOCK_MAX.
- Single module `mem_arbiter`; no sub-module. The state register, `lcnt`, `boost`, `last` and the `rvalid` flops all live in one sequential block.

## Test plan
- Reset with both requesting: all grants and `rvalid` are 0 during reset; first cycle after reset, `dma_gnt`=1.
- CPU-only read of 0x10 holding 0x2A: `cpu_gnt` in N, `cpu_rvalid`=1 with `cpu_rdata`=0x2A in N+1; `dma_rvalid` stays 0.
- DMA locked burst, LOCK_MAX=4, CPU requesting throughout: 4 DMA beats, then `busy` falls and the CPU is granted in the next cycle via `boost`.
- Tie handling:
  - `MEM_ARB_RR_EN` defined, both requesting continuously: grants alternate D,C,D,C.
  - Undefined: DMA is granted every cycle.
- Reset asserted the cycle after a granted CPU read: `cpu_rvalid` stays 0 and the state is ARB_IDLE.
- DMA write of 0x55 to 0x00, then CPU read of 0x00: `cpu_rdata`=0x55.

Source files
------------

// File: rtl/machine_pkg.sv
// Shared types and default sizes for the machine's memory arbiter.
package machine_pkg;

  localparam int ARB_ADDR_W   = 8;
  localparam int ARB_DATA_W   = 8;
  localparam int ARB_LOCK_MAX = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between CPU and DMA/loader, one access per cycle.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed DMA priority.
//
// state    | meaning
// ARB_IDLE | normal arbitration between CPU and DMA
// ARB_LOCK | DMA owns the RAM for a bounded burst; CPU is held off
module mem_arbiter
  import machine_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int LOCK_MAX = ARB_LOCK_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int LCNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [LCNT_W-1:0] LCNT_ONE = LCNT_W'(1);
  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCK_MAX);

  arb_state_t        state_q, state_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d, lcnt_inc;
  logic              boost_q, boost_d;
  logic              cpu_rvalid_q, dma_rvalid_q;
`ifdef MEM_ARB_RR_EN
  arb_owner_t        last_q, last_d;
`endif

  assign lcnt_inc = lcnt_q + LCNT_ONE;

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (state_q == ARB_LOCK) begin
        dma_gnt = dma_req;
      end else if (cpu_req && dma_req) begin
`ifdef MEM_ARB_RR_EN
        if (boost_q || last_q == OWN_DMA) cpu_gnt = 1'b1;
        else                              dma_gnt = 1'b1;
`else
        if (boost_q) cpu_gnt = 1'b1;
        else         dma_gnt = 1'b1;
`endif
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    boost_d = boost_q;
    case (state_q)
      ARB_IDLE: begin
        boost_d = 1'b0;
        lcnt_d  = '0;
        if (dma_gnt && dma_lock) begin
          // With LOCK_MAX of 1 the entry beat already completes the burst.
          if (LCNT_ONE >= LCNT_MAX) begin
            boost_d = 1'b1;
          end else begin
            state_d = ARB_LOCK;
            lcnt_d  = LCNT_ONE;
          end
        end
      end
      ARB_LOCK: begin
        if (!dma_gnt) begin
          state_d = ARB_IDLE;
          lcnt_d  = '0;
        end else if (lcnt_inc >= LCNT_MAX) begin
          state_d = ARB_IDLE;
          lcnt_d  = '0;
          boost_d = 1'b1;
        end else if (!dma_lock) begin
          state_d = ARB_IDLE;
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_inc;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        lcnt_d  = '0;
      end
    endcase
  end

`ifdef MEM_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (cpu_gnt)      last_d = OWN_CPU;
    else if (dma_gnt) last_d = OWN_DMA;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      lcnt_q       <= '0;
      boost_q      <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q       <= OWN_CPU;
`endif
    end else begin
      state_q      <= state_d;
      lcnt_q       <= lcnt_d;
      boost_q      <= boost_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      dma_rvalid_q <= dma_gnt & ~dma_we;
`ifdef MEM_ARB_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  // Gating with reset drops a read whose data would return during reset.
  assign cpu_rvalid = cpu_rvalid_q & ~reset;
  assign dma_rvalid = dma_rvalid_q & ~reset;
  assign cpu_rdata  = ram_rdata;
  assign dma_rdata  = ram_rdata;

  assign ram_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
  assign ram_addr  = dma_gnt ? dma_addr  : cpu_addr;
  assign ram_wdata = dma_gnt ? dma_wdata : cpu_wdata;

  assign busy = (state_q == ARB_LOCK);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural single-port RAM.
module tb_mem_arbiter;

  logic       clk, reset;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [7:0] dma_addr, dma_wdata, dma_rdata;
  logic       ram_we, busy;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  logic [7:0] ram_mem   [256];
  logic [7:0] model_mem [256];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       c;
    logic       d;
    logic [7:0] data;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  typedef struct {
    logic       c_req, c_we;
    logic [7:0] c_addr, c_wdata;
    logic       d_req, d_we;
    logic [7:0] d_addr, d_wdata;
    logic       e_cg, e_dg, e_we;
    logic [7:0] e_addr, e_wdata;
  } vec_t;
  vec_t vecs[11];

  logic tie_dma[4];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic dr, input logic dw, input logic dl,
                       input logic [7:0] da, input logic [7:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
  endtask

  // Checks grants/busy now and the read return scheduled by earlier grants,
  // then schedules this cycle's read return and advances one clock.
  task automatic run_cycle(input string tag, input logic ecg, input logic edg,
                           input logic ebusy, input int settle);
    rd_exp_t e, n;
    #(settle);
    check({tag, "_cpu_gnt"}, {7'b0, cpu_gnt}, {7'b0, ecg});
    check({tag, "_dma_gnt"}, {7'b0, dma_gnt}, {7'b0, edg});
    check({tag, "_busy"}, {7'b0, busy}, {7'b0, ebusy});
    e = '{c: 1'b0, d: 1'b0, data: 8'h00};
    if (sb_q.size() > 0) e = sb_q.pop_front();
    if (reset) begin
      e.c = 1'b0;
      e.d = 1'b0;
    end
    check({tag, "_cpu_rvalid"}, {7'b0, cpu_rvalid}, {7'b0, e.c});
    check({tag, "_dma_rvalid"}, {7'b0, dma_rvalid}, {7'b0, e.d});
    if (e.c) check({tag, "_cpu_rdata"}, cpu_rdata, e.data);
    if (e.d) check({tag, "_dma_rdata"}, dma_rdata, e.data);
    n.c    = ecg & ~cpu_we;
    n.d    = edg & ~dma_we;
    n.data = model_mem[ecg ? cpu_addr : dma_addr];
    sb_q.push_back(n);
    if (ecg && cpu_we) model_mem[cpu_addr] = cpu_wdata;
    if (edg && dma_we) model_mem[dma_addr] = dma_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    //          c_req c_we c_addr c_wd  d_req d_we d_addr d_wd  cg dg we  addr  wdata
    vecs[0]  = '{1'b1, 1'b1, 8'h10, 8'h2A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10, 8'h2A};
    vecs[1]  = '{1'b0, 1'b0, 8'h33, 8'h44, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33, 8'h44};
    vecs[2]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1, 1'b1, 8'h00, 8'h55};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, 1'b1, 8'h40, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h40, 8'h77};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 8'h99, 8'hEE, 1'b1, 1'b1, 8'h41, 8'h12, 1'b0, 1'b1, 1'b1, 8'h41, 8'h12};
    vecs[8]  = '{1'b0, 1'b1, 8'h05, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h05, 8'hFF};
    vecs[9]  = '{1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};

`ifdef MEM_ARB_RR_EN
    tie_dma[0] = 1'b1; tie_dma[1] = 1'b0; tie_dma[2] = 1'b1; tie_dma[3] = 1'b0;
`else
    tie_dma[0] = 1'b1; tie_dma[1] = 1'b1; tie_dma[2] = 1'b1; tie_dma[3] = 1'b1;
`endif

    // Reset with both requesting
    reset = 1'b1;
    drive(1'b1, 1'b1, 8'h10, 8'h2A, 1'b1, 1'b1, 1'b0, 8'h11, 8'h3B);
    @(posedge clk);
    #1;
    run_cycle("rst0", 1'b0, 1'b0, 1'b0, 4);
    run_cycle("rst1", 1'b0, 1'b0, 1'b0, 4);
    reset = 1'b0;

    // Ties; the first cycle is also the first cycle after reset
    for (int i = 0; i < 4; i++)
      run_cycle($sformatf("tie%0d", i), ~tie_dma[i], tie_dma[i], 1'b0, 4);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata,
            vecs[i].d_req, vecs[i].d_we, 1'b0, vecs[i].d_addr, vecs[i].d_wdata);
      #4;
      check($sformatf("vec%0d_ram_we", i), {7'b0, ram_we}, {7'b0, vecs[i].e_we});
      check($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_ram_wdata", i), ram_wdata, vecs[i].e_wdata);
      run_cycle($sformatf("vec%0d", i), vecs[i].e_cg, vecs[i].e_dg, 1'b0, 0);
    end

    // Reset the cycle after a granted CPU read drops the read
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cycle("rdrop_gnt", 1'b1, 1'b0, 1'b0, 4);
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cycle("rdrop_rst", 1'b0, 1'b0, 1'b0, 4);
    reset = 1'b0;
    run_cycle("rdrop_post", 1'b0, 1'b0, 1'b0, 4);

    // Maximal locked burst with the CPU waiting throughout
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 1'b1, 8'h20 + 8'(i), 8'hA0 + 8'(i));
      run_cycle($sformatf("burst%0d", i), 1'b0, 1'b1, (i != 0), 4);
    end
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 1'b1, 8'h24, 8'hA4);
    run_cycle("burst_boost", 1'b1, 1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cycle("burst_done", 1'b0, 1'b0, 1'b0, 4);

    // Lock released by DMA dropping its request
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h30, 8'hB0);
    run_cycle("drop_enter", 1'b0, 1'b1, 1'b0, 4);
    drive(1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cycle("drop_lock", 1'b0, 1'b0, 1'b1, 4);
    run_cycle("drop_cpu", 1'b1, 1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cycle("drop_done", 1'b0, 1'b0, 1'b0, 4);

    // Lock released by an unlocked beat, which is still performed
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h31, 8'hB1);
    run_cycle("unlk_enter", 1'b0, 1'b1, 1'b0, 4);
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    run_cycle("unlk_beat", 1'b0, 1'b1, 1'b1, 4);
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cycle("unlk_cpu", 1'b1, 1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cycle("unlk_done", 1'b0, 1'b0, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
